// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory load/store unit.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_B   = 2'b00,
        MEM_H   = 2'b01,
        MEM_W   = 2'b10,
        MEM_BAD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } fsm_state_e;

    function automatic logic is_misaligned(input mem_size_e size,
                                           input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            MEM_H:   bad = addr_lo[0];
            MEM_W:   bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_memory_lsu_if.sv
// Request/response channel between the MEM stage and the data memory.
interface data_memory_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size,
        output req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size,
        input  req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module lsu_lane_align
    import mem_pkg::*;
(
    input  mem_size_e   size_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic        unsigned_i,
    input  logic [31:0] raw_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = '0;
        rdata_o = '0;
        byte_v  = 8'(raw_i >> {addr_i, 3'b000});
        half_v  = addr_i[1] ? raw_i[31:16] : raw_i[15:0];
        case (size_i)
            MEM_B: begin
                be_o    = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{!unsigned_i && byte_v[7]}}, byte_v};
            end
            MEM_H: begin
                be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{!unsigned_i && half_v[15]}}, half_v};
            end
            MEM_W: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = raw_i;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressable data memory behind the MEM stage.
// One request in flight; fixed access latency; B/H/W loads and stores.
module data_memory_lsu
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic              clk,
    input logic              rst,
    data_memory_lsu_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    logic [31:0] mem [0:DEPTH_WORDS-1];

    fsm_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, uns_q;
    logic [ADDR_W-1:0] addr_q;
    mem_size_e         size_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              in_idle, accept, enter_resp;
    logic              cur_we, cur_uns, cur_oor, cur_err;
    logic [ADDR_W-1:0] cur_addr;
    mem_size_e         cur_size;
    logic [31:0]       cur_wdata;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        be;
    logic [31:0]       wpos, ldval, raw;

    assign in_idle = (state_q == IDLE);
    assign accept  = bus.req_valid && bus.req_ready;

    // With LATENCY==1 the commit edge is the accept edge, so use live inputs.
    assign cur_we    = in_idle ? bus.req_we : we_q;
    assign cur_uns   = in_idle ? bus.req_unsigned : uns_q;
    assign cur_addr  = in_idle ? bus.req_addr : addr_q;
    assign cur_size  = in_idle ? mem_size_e'(bus.req_size) : size_q;
    assign cur_wdata = in_idle ? bus.req_wdata : wdata_q;

    assign idx     = cur_addr[IDX_W+1:2];
    assign cur_oor = (cur_addr >> 2) >= ADDR_W'(DEPTH_WORDS);
    assign cur_err = cur_oor || (cur_size == MEM_BAD)
                     || is_misaligned(cur_size, cur_addr[1:0]);
    assign raw     = mem[idx];

    lsu_lane_align u_align (
        .size_i    (cur_size),
        .addr_i    (cur_addr[1:0]),
        .wdata_i   (cur_wdata),
        .unsigned_i(cur_uns),
        .raw_i     (raw),
        .be_o      (be),
        .wdata_o   (wpos),
        .rdata_o   (ldval)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    assign err_d      = cur_err;
    assign rdata_d    = (cur_err || cur_we) ? 32'h0 : ldval;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            size_q  <= mem_size_e'(bus.req_size);
            wdata_q <= bus.req_wdata;
        end
    end

    // Loads read `raw` combinationally, so they see the pre-write word.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && cur_we && !cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wpos[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = in_idle && !rst;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench: four LSU instances with LATENCY 1, 2, 3 and 5.
module tb_data_memory_lsu;
    logic clk;
    logic        t_rst[4], t_valid[4], t_we[4], t_uns[4];
    logic [31:0] t_addr[4], t_wdata[4];
    logic [1:0]  t_size[4];
    logic        o_ready[4], o_valid[4], o_err[4];
    logic [31:0] o_rdata[4];

    int vectors = 0;
    int miscompares = 0;

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : (s == 1) ? 2 : (s == 2) ? 3 : 5;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        data_memory_lsu_if #(.ADDR_W(32)) bus ();
        assign bus.req_valid    = t_valid[g];
        assign bus.req_we       = t_we[g];
        assign bus.req_addr     = t_addr[g];
        assign bus.req_size     = t_size[g];
        assign bus.req_unsigned = t_uns[g];
        assign bus.req_wdata    = t_wdata[g];
        assign o_ready[g]       = bus.req_ready;
        assign o_valid[g]       = bus.rsp_valid;
        assign o_rdata[g]       = bus.rsp_rdata;
        assign o_err[g]         = bus.rsp_err;
        data_memory_lsu #(
            .ADDR_W     (32),
            .DEPTH_WORDS(1024),
            .LATENCY    ((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 5)
        ) u_dut (
            .clk(clk),
            .rst(t_rst[g]),
            .bus(bus.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic we, input logic [31:0] a,
                         input logic [1:0] sz, input logic u,
                         input logic [31:0] wd);
        t_we[s] = we; t_addr[s] = a; t_size[s] = sz;
        t_uns[s] = u; t_wdata[s] = wd;
    endtask

    task automatic op(input int s, input logic we, input logic [31:0] a,
                      input logic [1:0] sz, input logic u,
                      input logic [31:0] wd, input logic [31:0] er,
                      input logic ee, input string tag);
        int k;
        bit bad_rdy;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(o_ready[s]), 32'd1);
        drive(s, we, a, sz, u, wd);
        t_valid[s] = 1'b1;
        k = 0;
        bad_rdy = 1'b0;
        do begin
            @(negedge clk);
            k++;
            t_valid[s] = 1'b0;
            if (!o_valid[s] && o_ready[s] !== 1'b0) bad_rdy = 1'b1;
        end while (!o_valid[s] && k < 20);
        chk({tag, "_lat"}, 32'(k), 32'(lat_of(s)));
        chk({tag, "_busy"}, 32'(bad_rdy), 32'd0);
        chk({tag, "_rdata"}, o_rdata[s], er);
        chk({tag, "_err"}, 32'(o_err[s]), 32'(ee));
    endtask

    int sels[3] = '{0, 1, 3};
    int s, L, P, pulses;
    bit seen, bad_t, bad_d, bad_r;

    initial begin
        for (int i = 0; i < 4; i++) begin
            t_rst[i] = 1'b1; t_valid[i] = 1'b0;
            drive(i, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk("rst_ready", 32'(o_ready[i]), 32'd0);
        chk("rst_valid", 32'(o_valid[1]), 32'd0);
        chk("rst_rdata", o_rdata[1], 32'h0);
        chk("rst_err", 32'(o_err[1]), 32'd0);
        for (int i = 0; i < 4; i++) t_rst[i] = 1'b0;

        op(1, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0, "t1_stw");
        op(1, 0, 32'h10, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0, "t1_ldw");
        repeat (2) @(negedge clk);
        chk("t1_hold_rdata", o_rdata[1], 32'hDEADBEEF);
        chk("t1_hold_valid", 32'(o_valid[1]), 32'd0);

        op(1, 1, 32'h11, 2'b00, 0, 32'h80, 32'h0, 0, "t2_stb");
        op(1, 0, 32'h11, 2'b00, 0, 32'h0, 32'hFFFFFF80, 0, "t2_ldb_s");
        op(1, 0, 32'h11, 2'b00, 1, 32'h0, 32'h00000080, 0, "t2_ldb_u");
        op(1, 0, 32'h10, 2'b10, 0, 32'h0, 32'hDEAD80EF, 0, "t2_ldw");

        op(1, 1, 32'h12, 2'b01, 0, 32'h1234, 32'h0, 0, "t3_sth");
        op(1, 0, 32'h12, 2'b01, 0, 32'h0, 32'h00001234, 0, "t3_ldh");
        op(1, 0, 32'h10, 2'b01, 0, 32'h0, 32'hFFFF80EF, 0, "t3_ldh_s");
        op(1, 0, 32'h10, 2'b01, 1, 32'h0, 32'h000080EF, 0, "t3_ldh_u");
        op(1, 0, 32'h13, 2'b01, 0, 32'h0, 32'h0, 1, "t3_ldh_mis");
        op(1, 1, 32'h14, 2'b10, 0, 32'h0BADF00D, 32'h0, 0, "t3_stw14");
        op(1, 1, 32'h16, 2'b10, 0, 32'hFFFFFFFF, 32'h0, 1, "t3_stw_mis");
        op(1, 0, 32'h14, 2'b10, 0, 32'h0, 32'h0BADF00D, 0, "t3_ldw14");
        op(1, 0, 32'h10, 2'b10, 0, 32'h0, 32'h123480EF, 0, "t3_ldw10");

        op(1, 1, 32'h0, 2'b10, 0, 32'h00000055, 32'h0, 0, "t4_stw0");
        op(1, 0, 32'h1000, 2'b10, 0, 32'h0, 32'h0, 1, "t4_ld_oor");
        op(1, 1, 32'h1000, 2'b10, 0, 32'h000000AA, 32'h0, 1, "t4_st_oor");
        op(1, 0, 32'h0, 2'b10, 0, 32'h0, 32'h00000055, 0, "t4_ldw0");
        op(1, 0, 32'h10, 2'b11, 0, 32'h0, 32'h0, 1, "t4_bad_size");

        op(2, 1, 32'h20, 2'b10, 0, 32'h11111111, 32'h0, 0, "t5_pre");
        @(negedge clk);
        drive(2, 1'b1, 32'h20, 2'b10, 1'b0, 32'h22222222);
        t_valid[2] = 1'b1;
        @(negedge clk);
        t_rst[2] = 1'b1;
        drive(2, 1'b1, 32'h20, 2'b10, 1'b0, 32'h33333333);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (o_valid[2]) seen = 1'b1;
            chk("t5_rdy_rst", 32'(o_ready[2]), 32'd0);
        end
        t_rst[2] = 1'b0;
        t_valid[2] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (o_valid[2]) seen = 1'b1;
        end
        chk("t5_no_rsp", 32'(seen), 32'd0);
        op(2, 0, 32'h20, 2'b10, 0, 32'h0, 32'h11111111, 0, "t5_ld");

        for (int j = 0; j < 3; j++) begin
            s = sels[j];
            L = lat_of(s);
            P = L + 1;
            pulses = 0;
            bad_t = 1'b0; bad_d = 1'b0; bad_r = 1'b0;
            op(s, 1, 32'h40, 2'b10, 0, 32'hA5A50000 + 32'(s), 32'h0, 0,
               "t6_st");
            @(negedge clk);
            drive(s, 1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
            t_valid[s] = 1'b1;
            for (int k = 1; k <= 3 * P; k++) begin
                @(negedge clk);
                if (o_valid[s]) begin
                    pulses++;
                    if (k % P != L) bad_t = 1'b1;
                    if (o_rdata[s] !== 32'hA5A50000 + 32'(s)) bad_d = 1'b1;
                end
                if (o_ready[s] !== ((k % P) == 0)) bad_r = 1'b1;
                if (k == 3 * P) t_valid[s] = 1'b0;
                else if (k % P == 0)
                    drive(s, 1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
                else
                    drive(s, 1'b1, 32'h44, 2'b00, 1'b1, 32'hFFFFFFFF);
            end
            chk("t6_pulses", 32'(pulses), 32'd3);
            chk("t6_spacing", 32'(bad_t), 32'd0);
            chk("t6_data", 32'(bad_d), 32'd0);
            chk("t6_ready", 32'(bad_r), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
